// File: rtl/mem_responder.sv
// mem_responder: two-channel (fetch / memory) request responder in front of a
// 32-bit word store. One access at a time, fixed priority to the memory
// channel, three-cycle request-to-response latency when uncontended.
module mem_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  // fetch channel
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  // memory channel
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic        mode;   // 0 read, 1 write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e state_q, state_d;

  logic fpend_q, fpend_d;
  logic mpend_q, mpend_d;
  req_t fhold_q, fhold_d;
  req_t mhold_q, mhold_d;

  // grant decode (FSM outputs)
  logic gnt_mem, gnt_fetch, gnt_any;

  // request chosen for the next grant, and its decoded address
  req_t                  sel_req;
  logic [ADDR_WIDTH-1:0] sel_idx;
  logic                  sel_oor;

  // in-flight transaction
  logic                  cur_mem_q;
  logic                  cur_mode_q;
  logic                  cur_oor_q;
  logic [ADDR_WIDTH-1:0] cur_idx_q;

  logic [31:0] fresp_q, mresp_q;
  logic [31:0] rdata;

  // backing store; never reset so writes survive a reset
  logic [31:0] mem_q [DEPTH];

  // addr[1:0] is a byte offset inside the word and carries no meaning here
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^sel_req.addr[1:0];

  // Pick the request that would be granted: memory channel has priority
  always_comb begin
    sel_req = mpend_q ? mhold_q : fhold_q;
    sel_idx = sel_req.addr[ADDR_WIDTH+1:2];
    sel_oor = |sel_req.addr[31:ADDR_WIDTH+2];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mpend_q || fpend_q) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grants in IDLE, response pulse in RESP (forced low in reset)
  always_comb begin
    gnt_mem               = (state_q == IDLE) && mpend_q;
    gnt_fetch             = (state_q == IDLE) && !mpend_q && fpend_q;
    gnt_any               = gnt_mem || gnt_fetch;
    mem_response_enable   = (state_q == RESP) && cur_mem_q && !rst;
    fetch_response_enable = (state_q == RESP) && !cur_mem_q && !rst;
  end

  // Pending flags: a pulse is taken when the flag is free or being granted
  // this cycle (the new request replaces the one leaving), otherwise dropped
  always_comb begin
    mpend_d = mpend_q;
    mhold_d = mhold_q;
    fpend_d = fpend_q;
    fhold_d = fhold_q;
    if (gnt_mem)   mpend_d = 1'b0;
    if (gnt_fetch) fpend_d = 1'b0;
    if (mem_request_enable && (!mpend_q || gnt_mem)) begin
      mpend_d = 1'b1;
      mhold_d = '{mode: mreq_mode, addr: mreq_addr, wdata: mreq_wdata, wstrb: mreq_wstrb};
    end
    if (fetch_request_enable && (!fpend_q || gnt_fetch)) begin
      fpend_d = 1'b1;
      fhold_d = '{mode: freq_mode, addr: freq_addr, wdata: freq_wdata, wstrb: freq_wstrb};
    end
  end

  // Pending flags and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mpend_q <= 1'b0;
      fpend_q <= 1'b0;
      mhold_q <= '0;
      fhold_q <= '0;
    end else begin
      mpend_q <= mpend_d;
      fpend_q <= fpend_d;
      mhold_q <= mhold_d;
      fhold_q <= fhold_d;
    end
  end

  // Latch the granted transaction for the ACCESS/RESP phases
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mem_q  <= 1'b0;
      cur_mode_q <= 1'b0;
      cur_oor_q  <= 1'b0;
      cur_idx_q  <= '0;
    end else if (gnt_any) begin
      cur_mem_q  <= gnt_mem;
      cur_mode_q <= sel_req.mode;
      cur_oor_q  <= sel_oor;
      cur_idx_q  <= sel_idx;
    end
  end

  // Writes land at grant time; out-of-range or zero-strobe writes touch nothing
  always_ff @(posedge clk) begin
    if (!rst && gnt_any && sel_req.mode && !sel_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_req.wstrb[b]) mem_q[sel_idx][8*b +: 8] <= sel_req.wdata[8*b +: 8];
      end
    end
  end

  // Response data: stored word for in-range reads, zero for writes and misses
  always_comb begin
    rdata = (cur_mode_q || cur_oor_q) ? 32'h0 : mem_q[cur_idx_q];
  end

  // Register response data in ACCESS; it holds until the next response
  always_ff @(posedge clk) begin
    if (rst) begin
      mresp_q <= '0;
      fresp_q <= '0;
    end else if (state_q == ACCESS) begin
      if (cur_mem_q) mresp_q <= rdata;
      else           fresp_q <= rdata;
    end
  end

  // Data outputs read as zero while reset is held
  always_comb begin
    mresp_data = rst ? 32'h0 : mresp_q;
    fresp_data = rst ? 32'h0 : fresp_q;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL give the word-address width (4096 x 32-bit words of backing store).
REQ-002 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 fetch_request_enable  input  1  SHALL be a one-cycle request pulse on the fetch channel.
REQ-005 freq_mode  input  1  SHALL select the fetch access type: 0 read, 1 write.
REQ-006 freq_addr  input  32  SHALL be the fetch byte address.
REQ-007 freq_wdata  input  32  SHALL be the fetch write data.
REQ-008 freq_wstrb  input  4  SHALL be the fetch byte strobes; bit i enables byte lane i.
REQ-009 fetch_response_enable  output  1  SHALL be a one-cycle response pulse on the fetch channel.
REQ-010 fresp_data  output  32  SHALL be the fetch response data.
REQ-011 mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  input  1/1/32/32/4  SHALL be the memory-channel equivalents of REQ-004..REQ-008.
REQ-012 mem_response_enable, mresp_data  output  1/32  SHALL be the memory-channel equivalents of REQ-009..REQ-010.

Function
REQ-013 Each request pulse SHALL set that channel's pending flag and capture mode, addr, wdata and wstrb into that channel's holding registers.
REQ-014 If a request pulse arrives while the same channel's flag is already set, the block SHALL ignore the pulse and SHALL keep the held request unchanged.
REQ-015 If a request pulse arrives in the same cycle its channel is granted, the set SHALL win, and the new request SHALL be held.
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 In IDLE with any flag set, the FSM SHALL grant exactly one channel, clear that channel's flag, perform the access, and go to ACCESS.
REQ-018 The FSM SHALL go from ACCESS to RESP unconditionally, after which read data SHALL be registered.
REQ-019 In RESP the FSM SHALL pulse the granted channel's response enable for exactly one cycle and SHALL return to IDLE.
REQ-020 With no contention, a request sampled in cycle T SHALL produce its response pulse in cycle T+3.
REQ-021 Priority SHALL be fixed with the memory channel over the fetch channel; on simultaneous pending, the fetch response SHALL follow the memory response by 3 cycles.
REQ-022 The word index SHALL be addr[ADDR_WIDTH+1:2]; addr[1:0] SHALL be ignored.
REQ-023 Any set bit in addr[31:ADDR_WIDTH+2] SHALL make the address out of range.
REQ-024 For a read, response data SHALL be the stored word, or 0 when the address is out of range.
REQ-025 For a write, only the strobed byte lanes SHALL be updated; an out-of-range write SHALL change no storage; response data SHALL be 0.
REQ-026 A write with wstrb=0 SHALL still produce a response and SHALL change no storage.
REQ-027 Outside the response cycle, response data outputs SHALL hold their last value; only the enable outputs carry meaning.
REQ-028 The two response enables SHALL never both be 1 in the same cycle.

Reset
REQ-029 While rst=1, state SHALL be IDLE, both pending flags 0, both response enables 0 and both response data outputs 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction and produce no response pulse afterwards.
REQ-031 A write already performed before reset SHALL remain; storage contents SHALL not be reset.
REQ-032 Request pulses coincident with rst=1 SHALL be discarded.

Verification
REQ-033 Write then read: mem write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF at T -> mem_response_enable at T+3, data 0; then fetch read 0x10 -> fresp_data 0xDEADBEEF after 3 cycles.
REQ-034 Partial write: word 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 0x5 -> reading 0x20 returns 0x11BB33DD.
REQ-035 Contention: fetch read and mem read in the same cycle T -> mem response at T+3 and fetch response at T+6; the two enables are never coincident.
REQ-036 Out of range: read 0x0001_0000 -> data 0; write 0xFFFF_FFFF to 0x0001_0000 -> word 0 unchanged.
REQ-037 Reset mid-operation: assert rst during ACCESS -> no response pulse, FSM in IDLE; a fresh request afterwards completes in 3 cycles.
REQ-038 Duplicate pulse: a second mem pulse while pending, with a different address -> exactly one response, for the first address.
